// File: rtl/pq_pkg.sv
// Shared constants and the return-path beat format for the ping-pong controller.
package pq_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int RD_LAT     = 2;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int LEN_W      = ADDR_WIDTH + 1;
  localparam int SKID       = RD_LAT + 1;
  localparam int CNT_W      = $clog2(SKID + 1);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

endpackage

// File: rtl/pq_skid_fifo.sv
// Small synchronous FIFO that absorbs read data issued before downstream stalled.
module pq_skid_fifo
  import pq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_WIDTH:0] din,
  input  logic              pop,
  output logic [DATA_WIDTH:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int PTR_W = (SKID > 1) ? $clog2(SKID) : 1;

  logic [DATA_WIDTH:0] mem [SKID];
  logic [PTR_W-1:0]    wr_idx;
  logic [PTR_W-1:0]    rd_idx;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wrap_inc(wr_idx);
      if (pop)  rd_idx <= wrap_inc(rd_idx);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= din;
  end

  assign dout  = mem[rd_idx];
  assign empty = (count == '0);

endmodule

// File: rtl/pq_ctrl.sv
// Ping-pong bank controller: fills one bank from the write stream while the other
// bank is read out through a credit-limited return path into a skid FIFO.
module pq_ctrl
  import pq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  buf_ctrl,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_din,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  w_full;
  logic                  r_busy;
  logic [LEN_W-1:0]      w_len;
  logic [LEN_W-1:0]      r_len;
  logic [RD_LAT-1:0]     vld_pipe;
  logic [RD_LAT-1:0]     last_pipe;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [CNT_W:0]        credits_used;
  logic                  wr_fire;
  logic                  swap;
  logic                  rd_last;
  logic                  fifo_empty;
  logic                  pop;
  beat_t                 ret_beat;
  beat_t                 head_beat;

  assign in_ready    = !w_full && !rst;
  assign wr_fire     = in_valid && in_ready;
  assign buf_wr_en   = wr_fire;
  assign buf_wr_addr = wr_ptr;
  assign buf_din     = in_data;
  assign swap        = w_full && !r_busy;

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
  end

  // A read may issue only if its word is guaranteed a FIFO slot on return.
  assign credits_used = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign buf_rd_en    = r_busy && (credits_used < (CNT_W + 1)'(SKID));
  assign buf_rd_addr  = rd_ptr;
  assign rd_last      = ({1'b0, rd_ptr} == r_len - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_ctrl  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      w_full    <= 1'b0;
      r_busy    <= 1'b0;
      w_len     <= '0;
      r_len     <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == ADDR_WIDTH'(DEPTH - 1) || in_last) begin
          w_full <= 1'b1;
          w_len  <= {1'b0, wr_ptr} + 1'b1;
        end
      end
      // Swap and write/read issue are mutually exclusive by their enabling flags.
      if (swap) begin
        buf_ctrl <= ~buf_ctrl;
        r_len    <= w_len;
        rd_ptr   <= '0;
        r_busy   <= 1'b1;
        w_full   <= 1'b0;
        wr_ptr   <= '0;
      end
      if (buf_rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (rd_last) r_busy <= 1'b0;
      end
      vld_pipe  <= (vld_pipe << 1) | RD_LAT'(buf_rd_en);
      last_pipe <= (last_pipe << 1) | RD_LAT'(buf_rd_en && rd_last);
    end
  end

  assign ret_beat = '{last: last_pipe[RD_LAT-1], data: buf_dout};
  assign pop      = out_valid && out_ready;

  pq_skid_fifo u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe[RD_LAT-1]),
    .din   (ret_beat),
    .pop   (pop),
    .dout  (head_beat),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head_beat.data;
  assign out_last  = head_beat.last;

endmodule

// File: tb/tb_pq_ctrl.sv
// Directed bench for pq_ctrl with a two-bank pq_buffer model and an output scoreboard.
module tb_pq_ctrl;
  import pq_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  buf_ctrl;
  logic                  buf_wr_en;
  logic [ADDR_WIDTH-1:0] buf_wr_addr;
  logic [DATA_WIDTH-1:0] buf_din;
  logic                  buf_rd_en;
  logic [ADDR_WIDTH-1:0] buf_rd_addr;
  logic [DATA_WIDTH-1:0] buf_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  always #5 clk = ~clk;

  pq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .buf_ctrl    (buf_ctrl),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_din     (buf_din),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .buf_dout    (buf_dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  // pq_buffer model: write bank = ctrl, read bank = ~ctrl, two-cycle read path.
  logic [DATA_WIDTH-1:0] bank [2][DEPTH];
  logic [DATA_WIDTH-1:0] rd_stage;
  always @(posedge clk) begin
    if (buf_wr_en === 1'b1) bank[buf_ctrl][buf_wr_addr] <= buf_din;
    if (buf_rd_en === 1'b1) rd_stage <= bank[~buf_ctrl][buf_rd_addr];
    buf_dout <= rd_stage;
  end

  logic [DATA_WIDTH:0]   sb [$];
  int                    checks = 0;
  int                    errors = 0;
  int                    rd_cnt = 0;
  logic                  rd_first_seen = 1'b1;
  logic [ADDR_WIDTH-1:0] rd_first_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [DATA_WIDTH:0] e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e[DATA_WIDTH-1:0]));
        check("out_last", 32'(out_last), 32'(e[DATA_WIDTH]));
      end
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b0 && buf_rd_en === 1'b1) begin
      rd_cnt++;
      if (!rd_first_seen) begin
        rd_first_seen = 1'b1;
        rd_first_addr = buf_rd_addr;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_WIDTH-1:0] d, input logic l, input logic el,
                      output logic [ADDR_WIDTH-1:0] waddr, output int stalls);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    stalls   = 0;
    waddr    = '0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc   = 1'b1;
        waddr = buf_wr_addr;
        break;
      end
      stalls++;
    end
    check("accept", 32'(acc), 1);
    if (acc) sb.push_back({el, d});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 600) begin
      step(1);
      n++;
    end
    check("drain", sb.size(), 0);
    step(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_WIDTH-1:0] wa;
    int                    st;
    int                    highs;

    // 1: reset holds in_ready low even with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    step(3);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_buf_ctrl", 32'(buf_ctrl), 0);
    in_valid = 1'b0;
    rst      = 1'b0;
    step(1);
    check("post_rst_in_ready", 32'(in_ready), 1);

    // 2: two full frames back-to-back
    for (int i = 0; i < 32; i++) begin
      send(8'(i), 1'b0, (i % 16) == 15, wa, st);
      if (i == 0 || i == 16) check("t2_waddr", 32'(wa), 0);
      if (i == 16) begin
        check("t2_stall", st, 1);
        check("t2_ctrl_swap1", 32'(buf_ctrl), 1);
      end
    end
    drain();
    check("t2_ctrl_swap2", 32'(buf_ctrl), 0);

    // 3: short frame closed by in_last, then a full frame
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h40 + i), i == 4, i == 4, wa, st);
      if (i == 0 || i == 4) check("t3_short_waddr", 32'(wa), i);
    end
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h80 + i), 1'b0, i == 15, wa, st);
      if (i == 0) check("t3_full_waddr", 32'(wa), 0);
    end
    drain();

    // 4: downstream stalled, only SKID reads may issue
    out_ready = 1'b0;
    rd_cnt    = 0;
    for (int i = 0; i < 16; i++) send(8'(8'hA0 + i), 1'b0, i == 15, wa, st);
    step(20);
    check("t4_rd_pulses", rd_cnt, SKID);
    check("t4_out_valid", 32'(out_valid), 1);
    check("t4_head", 32'(out_data), 32'(8'hA0));
    out_ready = 1'b1;
    drain();

    // 5: two frames while stalled, write side blocks until read bank is issued
    out_ready = 1'b0;
    rd_cnt    = 0;
    for (int i = 0; i < 32; i++) send(8'(i * 3 + 1), 1'b0, (i % 16) == 15, wa, st);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (in_ready !== 1'b0) highs++;
    end
    check("t5_in_ready_low", highs, 0);
    check("t5_rd_pulses", rd_cnt, SKID);
    out_ready = 1'b1;
    for (int i = 0; i < 200 && in_ready !== 1'b1; i++) step(1);
    check("t5_in_ready_back", 32'(in_ready), 1);
    check("t5_reads_issued", rd_cnt, 16);
    drain();

    // 6: reset in the middle of a frame discards it
    for (int i = 0; i < 7; i++) send(8'(8'h10 + i), 1'b0, 1'b0, wa, st);
    rst = 1'b1;
    step(1);
    check("t6_rst_in_ready", 32'(in_ready), 0);
    check("t6_rst_out_valid", 32'(out_valid), 0);
    check("t6_rst_buf_ctrl", 32'(buf_ctrl), 0);
    sb.delete();
    step(1);
    rst           = 1'b0;
    rd_cnt        = 0;
    rd_first_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'(8'hC0 + i), i == 3, i == 3, wa, st);
      if (i == 0) check("t6_waddr", 32'(wa), 0);
    end
    drain();
    check("t6_rd_first_seen", 32'(rd_first_seen), 1);
    check("t6_rd_first_addr", 32'(rd_first_addr), 0);
    check("t6_rd_pulses", rd_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
